// File: rtl/chan_err_pkg.sv
// Shared types, LFSR taps and saturating arithmetic for the channel error injector.
package chan_err_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        BURST  = 2'd1,
        RANDOM = 2'd2,
        SINGLE = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        GAP     = 2'd0,
        BURST_S = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    // Adds inc to val and clamps the result at lim instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] inc,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, val} + {1'b0, inc};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

endpackage

// File: rtl/chan_err_inj_lfsr.sv
// Galois LFSR that steps once per accepted symbol and reloads its seed on load.
module chan_err_lfsr #(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (step) begin
            state_d = state_q >> 1;
            if (state_q[0]) begin
                state_d = state_d ^ TAPS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/chan_err_inj.sv
// Channel impairment block: corrupts code symbols in OFF/BURST/RANDOM/SINGLE modes inside a window.
// Define CHAN_ERR_ERASURE_EN to add the erase_o soft-decision erasure hint.
module chan_err_inj
    import chan_err_pkg::*;
#(
    parameter int unsigned       SYM_W  = 2,
    parameter int unsigned       CNT_W  = 16,
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1),
    parameter int unsigned       THR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [SYM_W-1:0] sym_i,
    input  logic [1:0]       mode_i,
    input  logic [SYM_W-1:0] mask_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic [THR_W-1:0] thresh_i,
    input  logic [CNT_W-1:0] window_i,
    input  logic             clear_i,
    output logic             valid_o,
    output logic [SYM_W-1:0] sym_o,
    output logic [SYM_W-1:0] err_o,
    output logic [CNT_W-1:0] sym_cnt_o,
    output logic [CNT_W-1:0] inj_sym_cnt_o,
    output logic [CNT_W-1:0] inj_bit_cnt_o,
    output logic             window_done_o
`ifdef CHAN_ERR_ERASURE_EN
   ,output logic             erase_o
`endif
);

    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v, input logic [31:0] inc);
        return CNT_W'(sat_inc(32'(v), inc, CNT_MAX));
    endfunction

    logic              valid_q, valid_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic [SYM_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]  inj_sym_q, inj_sym_d;
    logic [CNT_W-1:0]  inj_bit_q, inj_bit_d;
    logic              done_q, done_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mode_e             last_mode_q, last_mode_d;
`ifdef CHAN_ERR_ERASURE_EN
    logic              erase_q, erase_d;
`endif

    logic [LFSR_W-1:0] lfsr_state;
    logic              lfsr_unused;
    logic              accept;
    mode_e             mode;
    state_e            eff_state, nxt_state;
    logic [CNT_W-1:0]  eff_cnt, nxt_cnt, blen, new_sym_cnt;
    logic              inject;
    logic [SYM_W-1:0]  flip;

    assign accept      = valid_i & ~clear_i;
    assign lfsr_unused = ^lfsr_state[LFSR_W-1:THR_W];

    chan_err_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (LFSR_W'(LFSR_TAPS_16))
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (accept),
        .load  (clear_i),
        .state (lfsr_state)
    );

    always_comb begin
        valid_d     = valid_i;
        sym_d       = sym_q;
        err_d       = err_q;
        sym_cnt_d   = sym_cnt_q;
        inj_sym_d   = inj_sym_q;
        inj_bit_d   = inj_bit_q;
        done_d      = done_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_mode_d = last_mode_q;
`ifdef CHAN_ERR_ERASURE_EN
        erase_d     = erase_q;
`endif
        mode      = mode_e'(mode_i);
        eff_state = state_q;
        eff_cnt   = cnt_q;
        inject    = 1'b0;
        // A mode switch restarts the burst pattern; an exhausted window stays exhausted.
        if (state_q != DONE && mode != last_mode_q) begin
            eff_state = GAP;
            eff_cnt   = '0;
        end
        blen      = (mode == SINGLE) ? CNT_W'(1) : burst_len_i;
        nxt_state = eff_state;
        nxt_cnt   = '0;

        if (eff_state != DONE) begin
            nxt_state = GAP;
            case (mode)
                BURST, SINGLE: begin
                    if (eff_state == BURST_S || (eff_cnt >= period_i && blen != '0)) begin
                        inject = 1'b1;
                        if (eff_state == BURST_S) begin
                            nxt_cnt = sat_cnt(eff_cnt, 32'd1);
                        end else begin
                            nxt_cnt = CNT_W'(1);
                        end
                        if (nxt_cnt >= blen) begin
                            nxt_cnt = '0;
                        end else begin
                            nxt_state = BURST_S;
                        end
                    end else begin
                        nxt_cnt = sat_cnt(eff_cnt, 32'd1);
                    end
                end
                RANDOM:  inject = (lfsr_state[THR_W-1:0] < thresh_i);
                default: ;
            endcase
        end

        flip        = inject ? mask_i : '0;
        new_sym_cnt = sat_cnt(sym_cnt_q, 32'd1);
        // The symbol that reaches the window is still eligible; everything after is clean.
        if (eff_state != DONE && window_i != '0 && new_sym_cnt >= window_i) begin
            nxt_state = DONE;
        end

        if (clear_i) begin
            sym_cnt_d = '0;
            inj_sym_d = '0;
            inj_bit_d = '0;
            done_d    = 1'b0;
            state_d   = GAP;
            cnt_d     = '0;
            if (valid_i) begin
                sym_d = sym_i;
                err_d = '0;
`ifdef CHAN_ERR_ERASURE_EN
                erase_d = 1'b0;
`endif
            end
        end else if (valid_i) begin
            sym_d       = sym_i ^ flip;
            err_d       = flip;
            sym_cnt_d   = new_sym_cnt;
            inj_sym_d   = (flip != '0) ? sat_cnt(inj_sym_q, 32'd1) : inj_sym_q;
            inj_bit_d   = sat_cnt(inj_bit_q, 32'($countones(flip)));
            state_d     = nxt_state;
            cnt_d       = nxt_cnt;
            done_d      = (nxt_state == DONE);
            last_mode_d = mode;
`ifdef CHAN_ERR_ERASURE_EN
            erase_d     = (flip != '0);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            sym_q       <= '0;
            err_q       <= '0;
            sym_cnt_q   <= '0;
            inj_sym_q   <= '0;
            inj_bit_q   <= '0;
            done_q      <= 1'b0;
            state_q     <= GAP;
            cnt_q       <= '0;
            last_mode_q <= OFF;
`ifdef CHAN_ERR_ERASURE_EN
            erase_q     <= 1'b0;
`endif
        end else begin
            valid_q     <= valid_d;
            sym_q       <= sym_d;
            err_q       <= err_d;
            sym_cnt_q   <= sym_cnt_d;
            inj_sym_q   <= inj_sym_d;
            inj_bit_q   <= inj_bit_d;
            done_q      <= done_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_mode_q <= last_mode_d;
`ifdef CHAN_ERR_ERASURE_EN
            erase_q     <= erase_d;
`endif
        end
    end

    assign valid_o       = valid_q;
    assign sym_o         = sym_q;
    assign err_o         = err_q;
    assign sym_cnt_o     = sym_cnt_q;
    assign inj_sym_cnt_o = inj_sym_q;
    assign inj_bit_cnt_o = inj_bit_q;
    assign window_done_o = done_q;
`ifdef CHAN_ERR_ERASURE_EN
    assign erase_o       = erase_q;
`endif

endmodule

// File: tb/tb_chan_err_inj.sv
// Randomised and directed bench for chan_err_inj against a positional reference model.
module tb_chan_err_inj;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_i = 1'b0;
    logic [1:0]  sym_i = '0;
    logic [1:0]  mode_i = '0;
    logic [1:0]  mask_i = '0;
    logic [15:0] period_i = '0;
    logic [15:0] burst_len_i = '0;
    logic [7:0]  thresh_i = '0;
    logic [15:0] window_i = '0;
    logic        clear_i = 1'b0;
    logic        valid_o;
    logic [1:0]  sym_o;
    logic [1:0]  err_o;
    logic [15:0] sym_cnt_o;
    logic [15:0] inj_sym_cnt_o;
    logic [15:0] inj_bit_cnt_o;
    logic        window_done_o;
`ifdef CHAN_ERR_ERASURE_EN
    logic        erase_o;
`endif

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Reference state: symbols since clear, position since last pattern restart, own LFSR.
    int          m_n, m_seg, m_last_mode;
    logic [15:0] m_lfsr;
    logic        e_valid, e_done;
    logic [1:0]  e_sym, e_err;
    int          e_sym_cnt, e_inj_sym, e_inj_bit;

    chan_err_inj u_dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .sym_i         (sym_i),
        .mode_i        (mode_i),
        .mask_i        (mask_i),
        .period_i      (period_i),
        .burst_len_i   (burst_len_i),
        .thresh_i      (thresh_i),
        .window_i      (window_i),
        .clear_i       (clear_i),
        .valid_o       (valid_o),
        .sym_o         (sym_o),
        .err_o         (err_o),
        .sym_cnt_o     (sym_cnt_o),
        .inj_sym_cnt_o (inj_sym_cnt_o),
        .inj_bit_cnt_o (inj_bit_cnt_o),
        .window_done_o (window_done_o)
`ifdef CHAN_ERR_ERASURE_EN
       ,.erase_o       (erase_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic model_reset();
        m_n = 0; m_seg = 0; m_last_mode = 0; m_lfsr = 16'hACE1;
        e_valid = 0; e_sym = 0; e_err = 0; e_done = 0;
        e_sym_cnt = 0; e_inj_sym = 0; e_inj_bit = 0;
    endtask

    task automatic model_step();
        int  per, blen, win, md;
        bit  inj, elig;
        logic [1:0] flip;
        e_valid = valid_i;
        if (clear_i) begin
            m_n = 0; m_seg = 0; m_lfsr = 16'hACE1;
            e_sym_cnt = 0; e_inj_sym = 0; e_inj_bit = 0; e_done = 0;
            if (valid_i) begin
                e_sym = sym_i; e_err = 0;
            end
        end else if (valid_i) begin
            md = int'(mode_i);
            if (md != m_last_mode) m_seg = 0;
            m_last_mode = md;
            per  = int'(period_i);
            win  = int'(window_i);
            blen = (md == 3) ? 1 : int'(burst_len_i);
            elig = (win == 0) || (m_n < win);
            inj  = 1'b0;
            if (md == 1 || md == 3) inj = (blen > 0) && ((m_seg % (per + blen)) >= per);
            else if (md == 2)       inj = (int'(m_lfsr[7:0]) < int'(thresh_i));
            flip  = (inj && elig) ? mask_i : 2'b00;
            e_sym = sym_i ^ flip;
            e_err = flip;
            e_inj_sym = sat16(e_inj_sym + ((flip != 0) ? 1 : 0));
            e_inj_bit = sat16(e_inj_bit + int'(flip[0]) + int'(flip[1]));
            m_n++;
            m_seg++;
            e_sym_cnt = sat16(m_n);
            if (win != 0 && m_n >= win) e_done = 1'b1;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Per-cycle comparison against the model, half a cycle away from the sampling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("valid_o", 32'(valid_o), 32'(e_valid));
                chk("sym_o", 32'(sym_o), 32'(e_sym));
                chk("err_o", 32'(err_o), 32'(e_err));
                chk("sym_cnt_o", 32'(sym_cnt_o), 32'(e_sym_cnt));
                chk("inj_sym_cnt_o", 32'(inj_sym_cnt_o), 32'(e_inj_sym));
                chk("inj_bit_cnt_o", 32'(inj_bit_cnt_o), 32'(e_inj_bit));
                chk("window_done_o", 32'(window_done_o), 32'(e_done));
`ifdef CHAN_ERR_ERASURE_EN
                chk("erase_o", 32'(erase_o), 32'(e_err != 0));
`endif
            end
        end
    end

    task automatic send(input logic [1:0] s, input bit v, input bit clr);
        @(negedge clk);
        sym_i = s; valid_i = v; clear_i = clr;
    endtask

    task automatic setup(input logic [1:0] md, input logic [1:0] msk, input int per,
                         input int bl, input int th, input int win);
        @(negedge clk);
        mode_i = md; mask_i = msk; period_i = 16'(per); burst_len_i = 16'(bl);
        thresh_i = 8'(th); window_i = 16'(win); clear_i = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        clear_i = 1'b0;
    endtask

    task automatic run(input int n, input bit gaps);
        int k = 0;
        while (k < n) begin
            bit v;
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            send(2'($urandom), v, 1'b0);
            if (v) k++;
        end
        send(2'b00, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, 32'(valid_o), 0);
        chk({nm, "_sym"}, 32'(sym_o), 0);
        chk({nm, "_err"}, 32'(err_o), 0);
        chk({nm, "_symcnt"}, 32'(sym_cnt_o), 0);
        chk({nm, "_injsym"}, 32'(inj_sym_cnt_o), 0);
        chk({nm, "_injbit"}, 32'(inj_bit_cnt_o), 0);
        chk({nm, "_done"}, 32'(window_done_o), 0);
    endtask

    initial begin
        logic [1:0] pin [7];
        logic [1:0] s;
        pin = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        #2 rst = 1'b1;
        cmp_en = 1'b1;

        // OFF: 300 clean symbols.
        setup(2'd0, 2'b11, 1, 1, 255, 0);
        for (int i = 0; i < 300; i++) send(2'b10, 1'b1, 1'b0);
        send(2'b00, 1'b0, 1'b0);
        chk("off_symcnt", 32'(sym_cnt_o), 300);
        chk("off_injsym", 32'(inj_sym_cnt_o), 0);
        chk("off_injbit", 32'(inj_bit_cnt_o), 0);

        // BURST period 6 length 2: symbols 6,7,14,15,... inverted.
        setup(2'd1, 2'b11, 6, 2, 0, 0);
        run(32, 1'b0);
        chk("burst_injsym", 32'(inj_sym_cnt_o), 8);
        chk("burst_injbit", 32'(inj_bit_cnt_o), 16);
        chk("burst_symcnt", 32'(sym_cnt_o), 32);

        // SINGLE period 3, window 10.
        setup(2'd3, 2'b01, 3, 0, 0, 10);
        for (int i = 0; i < 20; i++) begin
            send(2'($urandom), 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("single_err", 32'(err_o), (i == 3 || i == 7) ? 1 : 0);
            chk("single_done", 32'(window_done_o), (i >= 9) ? 1 : 0);
        end
        chk("single_injbit", 32'(inj_bit_cnt_o), 2);
        chk("single_symcnt", 32'(sym_cnt_o), 20);

        // RANDOM: threshold 0 never injects, threshold FF follows the LFSR.
        setup(2'd2, 2'b11, 0, 0, 0, 0);
        run(1000, 1'b1);
        chk("rand0_injsym", 32'(inj_sym_cnt_o), 0);
        setup(2'd2, 2'b11, 0, 0, 255, 0);
        run(1000, 1'b1);
        chk("randff_injsym", 32'(inj_sym_cnt_o), 32'(e_inj_sym));
        setup(2'd2, 2'b11, 0, 0, 8'h50, 0);
        for (int i = 0; i < 7; i++) begin
            send(2'($urandom), 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("rand_pin_err", 32'(err_o), 32'(pin[i]));
        end

        // Clear coincident with valid in the middle of a continuous burst.
        setup(2'd1, 2'b11, 0, 4, 0, 0);
        for (int i = 0; i < 6; i++) send(2'($urandom), 1'b1, 1'b0);
        s = 2'b01;
        send(s, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("clr_valid", 32'(valid_o), 1);
        chk("clr_sym", 32'(sym_o), 32'(s));
        chk("clr_err", 32'(err_o), 0);
        chk("clr_symcnt", 32'(sym_cnt_o), 0);
        chk("clr_injbit", 32'(inj_bit_cnt_o), 0);
        s = 2'b10;
        send(s, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("clr_next_err", 32'(err_o), 3);
        chk("clr_next_sym", 32'(sym_o), 32'(s ^ 2'b11));
        chk("clr_next_symcnt", 32'(sym_cnt_o), 1);
        send(2'b00, 1'b1, 1'b1);
        @(posedge clk); #1;
        mode_i = 2'd2; thresh_i = 8'h50;
        for (int i = 0; i < 7; i++) begin
            send(2'($urandom), 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("clr_lfsr_err", 32'(err_o), 32'(pin[i]));
        end

        // Asynchronous reset in the middle of a burst.
        setup(2'd1, 2'b11, 0, 4, 0, 0);
        for (int i = 0; i < 5; i++) send(2'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        period_i = 16'd2; burst_len_i = 16'd2;
        for (int i = 0; i < 3; i++) begin
            send(2'($urandom), 1'b1, 1'b0);
            @(posedge clk); #1;
            chk("post_rst_err", 32'(err_o), (i >= 2) ? 3 : 0);
        end

        // Randomised runs with mid-run mode switches and clear pulses.
        for (int r = 0; r < 16; r++) begin
            setup(2'($urandom), 2'($urandom_range(1, 3)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 255)),
                  ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 80)));
            for (int c = 0; c < 150; c++) begin
                int e;
                e = int'($urandom_range(0, 99));
                if (e < 3) begin
                    send(2'($urandom), 1'b1, 1'b1);
                end else if (e < 6) begin
                    mode_i = 2'($urandom);
                    send(2'($urandom), 1'b1, 1'b0);
                end else begin
                    send(2'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
                end
            end
            send(2'b00, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
